// File: rtl/fir_symmetric_stream.sv
// ---------------------------------------------------------------------------
// fir_symmetric_stream
//
// Linear-phase (symmetric, odd-length) FIR filter with a valid/ready
// streaming interface. A single pre-add / multiply / accumulate datapath is
// time-multiplexed over the HALF unique coefficients, so each sample costs
// HALF+2 cycles: HALF MAC cycles, one FINAL cycle that rounds and saturates,
// and one OUT cycle in which the result is handed downstream (the next
// sample can be accepted on that same cycle).
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   in_valid      in_data valid
//   in_ready      block accepts a sample this cycle (0 while reset is high)
//   in_data       signed input sample
//   out_valid     out_data valid; held until out_ready
//   out_ready     downstream accepts out_data
//   out_data      signed filtered, rounded, saturated sample
//   coef_wr_en    coefficient write strobe
//   coef_wr_addr  coefficient index 0..CENTER
//   coef_wr_data  signed coefficient, Q(COEF_WIDTH-FRAC_BITS).FRAC_BITS
//   coef_wr_ack   registered one-cycle pulse: write performed
//   sat           sticky: some output has been clamped since reset
// ---------------------------------------------------------------------------
module fir_symmetric_stream #(
    parameter int TAPS       = 11,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_WIDTH-1:0]         in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [DATA_WIDTH-1:0]         out_data,
    input  logic                                 coef_wr_en,
    input  logic [$clog2((TAPS+1)/2)-1:0]        coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]         coef_wr_data,
    output logic                                 coef_wr_ack,
    output logic                                 sat
);

    localparam int HALF   = (TAPS + 1) / 2;
    localparam int CENTER = HALF - 1;
    localparam int AW     = $clog2(HALF);
    localparam int XW     = $clog2(TAPS);
    // Full-precision product width: (DATA_WIDTH+1)-bit pre-sum times coefficient.
    localparam int PW     = DATA_WIDTH + COEF_WIDTH + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMac   = 2'd1;
    localparam logic [1:0] StFinal = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    localparam logic [AW-1:0] CenterIdx = AW'(CENTER);

    localparam logic signed [COEF_WIDTH-1:0] CoefUnity = COEF_WIDTH'(1) << FRAC_BITS;

    // Half an output LSB, added before the arithmetic shift: round half up.
    localparam logic signed [ACC_WIDTH-1:0] RoundBias = ACC_WIDTH'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH-1:0] YMax =
        (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] YMin = ~YMax;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]                   state_q, state_d;
    logic [AW-1:0]                k_q, k_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         sat_q, sat_d;
    logic                         ack_q;
    logic signed [DATA_WIDTH-1:0] x_q [TAPS];
    logic signed [COEF_WIDTH-1:0] coef_q [HALF];

    logic accept;
    logic coef_wr_ok;

    // -----------------------------------------------------------------------
    // Handshake and coefficient-write qualification
    // -----------------------------------------------------------------------
    assign in_ready = !reset && ((state_q == StIdle) || ((state_q == StOut) && out_ready));
    assign accept   = in_valid && in_ready;

    // Writes are only safe while the datapath is not walking the coefficients.
    assign coef_wr_ok = coef_wr_en
                     && ((state_q == StIdle) || (state_q == StOut))
                     && (coef_wr_addr <= CenterIdx);

    assign out_valid   = (state_q == StOut);
    assign out_data    = out_data_q;
    assign sat         = sat_q;
    assign coef_wr_ack = ack_q;

    // -----------------------------------------------------------------------
    // Pre-add / multiply datapath for the current tap pair k
    // -----------------------------------------------------------------------
    logic [XW-1:0]                far_idx;
    logic signed [DATA_WIDTH-1:0] x_near;
    logic signed [DATA_WIDTH-1:0] x_far;
    logic signed [COEF_WIDTH-1:0] coef_k;
    logic signed [DATA_WIDTH:0]   pre_sum;
    logic signed [PW-1:0]         product;
    logic signed [ACC_WIDTH-1:0]  term;

    always_comb begin
        far_idx = XW'(TAPS - 1) - XW'(k_q);
        x_near  = x_q[k_q];
        x_far   = x_q[far_idx];
        coef_k  = coef_q[k_q];

        // One extra bit so the sum of two full-scale samples cannot wrap.
        // The centre tap has no mirror partner and is used alone.
        if (k_q == CenterIdx) begin
            pre_sum = {x_near[DATA_WIDTH-1], x_near};
        end else begin
            pre_sum = {x_near[DATA_WIDTH-1], x_near} + {x_far[DATA_WIDTH-1], x_far};
        end

        product = $signed({{COEF_WIDTH{pre_sum[DATA_WIDTH]}}, pre_sum})
                * $signed({{(DATA_WIDTH + 1){coef_k[COEF_WIDTH-1]}}, coef_k});

        term = {{(ACC_WIDTH - PW){product[PW-1]}}, product};
    end

    // -----------------------------------------------------------------------
    // Round half up, then clamp to the output range
    // -----------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0]  rounded;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [DATA_WIDTH-1:0] y_clamped;
    logic                         y_sat;

    always_comb begin
        rounded = acc_q + RoundBias;
        shifted = rounded >>> FRAC_BITS;
        if (shifted > YMax) begin
            y_clamped = YMax[DATA_WIDTH-1:0];
            y_sat     = 1'b1;
        end else if (shifted < YMin) begin
            y_clamped = YMin[DATA_WIDTH-1:0];
            y_sat     = 1'b1;
        end else begin
            y_clamped = shifted[DATA_WIDTH-1:0];
            y_sat     = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMac;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end

            StMac: begin
                acc_d = acc_q + term;
                if (k_q == CenterIdx) begin
                    state_d = StFinal;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end

            StFinal: begin
                out_data_d = y_clamped;
                sat_d      = sat_q | y_sat;
                state_d    = StOut;
            end

            StOut: begin
                // out_data stays put until the downstream handshake; a sample
                // offered on that cycle is taken without an idle bubble.
                if (out_ready) begin
                    if (accept) begin
                        state_d = StMac;
                        k_d     = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            ack_q      <= coef_wr_ok;
        end
    end

    // -----------------------------------------------------------------------
    // Delay line: x[0] is the newest sample
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else if (accept) begin
            x_q[0] <= in_data;
            for (int i = 1; i < TAPS; i++) begin
                x_q[i] <= x_q[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Coefficient bank; resets to a pure CENTER-sample delay
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HALF; i++) begin
                coef_q[i] <= (i == CENTER) ? CoefUnity : '0;
            end
        end else if (coef_wr_ok) begin
            coef_q[coef_wr_addr] <= coef_wr_data;
        end
    end

endmodule

// File: tb/tb_fir_symmetric_stream.sv
// ---------------------------------------------------------------------------
// tb_fir_symmetric_stream
//
// Directed bench for fir_symmetric_stream with default parameters. A
// negedge monitor mirrors every accepted sample into a behavioural filter
// model and queues the expected output; outputs are popped and compared on
// each downstream handshake.
// ---------------------------------------------------------------------------
module tb_fir_symmetric_stream;

    localparam int TAPS   = 11;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int FB     = 8;
    localparam int ACCW   = 40;
    localparam int HALF   = (TAPS + 1) / 2;
    localparam int CENTER = HALF - 1;
    localparam int AW     = $clog2(HALF);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 coef_wr_en;
    logic [AW-1:0]        coef_wr_addr;
    logic signed [CW-1:0] coef_wr_data;
    logic                 coef_wr_ack;
    logic                 sat;

    fir_symmetric_stream #(
        .TAPS       (TAPS),
        .DATA_WIDTH (DW),
        .COEF_WIDTH (CW),
        .FRAC_BITS  (FB),
        .ACC_WIDTH  (ACCW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .coef_wr_ack  (coef_wr_ack),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    longint               mx [TAPS];
    longint               mc [HALF];
    bit                   m_sat;
    longint               q_y [$];
    bit                   q_c [$];
    int                   lat_q [$];
    logic signed [DW-1:0] last_out;
    bit                   ov_prev;
    bit                   period_chk;
    bit                   have_prev;
    int                   prev_acc;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) mx[i] = 0;
        for (int i = 0; i < HALF; i++) mc[i] = 0;
        mc[CENTER] = longint'(1) << FB;
        m_sat = 1'b0;
        q_y.delete();
        q_c.delete();
        lat_q.delete();
        have_prev = 1'b0;
    endtask

    task automatic model_accept(input logic signed [DW-1:0] d);
        longint acc;
        longint y;
        bit     c;
        for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = longint'(d);
        acc = mc[CENTER] * mx[CENTER];
        for (int k = 0; k < CENTER; k++) acc += mc[k] * (mx[k] + mx[TAPS-1-k]);
        y = (acc + (longint'(1) << (FB - 1))) >>> FB;
        c = 1'b0;
        if (y > 32767) begin
            y = 32767;
            c = 1'b1;
        end else if (y < -32768) begin
            y = -32768;
            c = 1'b1;
        end
        q_y.push_back(y);
        q_c.push_back(c);
    endtask

    // Monitor: handshakes observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !ov_prev) begin
                if (lat_q.size() > 0) begin
                    check("latency", 64'(cyc - lat_q[0]), 64'(HALF + 2));
                end else begin
                    vectors++;
                    miscompares++;
                    $error("FAIL spurious_out_valid: observed 1, expected 0");
                end
            end
            if (out_valid && out_ready) begin
                if (q_y.size() > 0) begin
                    m_sat = m_sat | q_c[0];
                    check("out_data", 64'(out_data), q_y[0]);
                    check("sat", 64'(sat), 64'(m_sat));
                    last_out = out_data;
                    void'(q_y.pop_front());
                    void'(q_c.pop_front());
                end else begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_output: observed %0d, expected none", out_data);
                end
                if (lat_q.size() > 0) void'(lat_q.pop_front());
            end
            if (in_valid && in_ready) begin
                model_accept(in_data);
                lat_q.push_back(cyc);
                if (period_chk) begin
                    if (have_prev) check("period", 64'(cyc - prev_acc), 64'(HALF + 2));
                    have_prev = 1'b1;
                    prev_acc  = cyc;
                end
            end
        end
        ov_prev = out_valid;
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic feed(input logic signed [DW-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout: observed in_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input int v, input bit exp_ack);
        coef_wr_en   = 1'b1;
        coef_wr_addr = AW'(a);
        coef_wr_data = CW'(v);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        check("coef_ack", 64'(coef_wr_ack), 64'(exp_ack));
        if (exp_ack && a < HALF) mc[a] = longint'(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (q_y.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 64'(q_y.size()), 64'(0));
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        out_ready  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_valid_rise", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        period_chk   = 1'b0;
        last_out     = '0;
        model_reset();

        // Reset defaults
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_ack", 64'(coef_wr_ack), 64'(0));
        check("rst_sat", 64'(sat), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // Impulse through the default passthrough, streaming at full rate
        period_chk = 1'b1;
        have_prev  = 1'b0;
        feed(16'sd100);
        repeat (10) feed(16'sd0);
        in_valid   = 1'b0;
        period_chk = 1'b0;
        drain();
        check("impulse_tail", 64'(last_out), 64'(0));
        check("impulse_sat", 64'(sat), 64'(0));

        // Unity on every coefficient: running 11-sample sum
        for (int a = 0; a < HALF; a++) write_coef(a, 256, 1'b1);
        repeat (12) feed(16'sd1000);
        in_valid = 1'b0;
        drain();
        check("ramp_hold", 64'(last_out), 64'(11000));

        // Positive saturation
        repeat (12) feed(16'sd32767);
        in_valid = 1'b0;
        drain();
        check("sat_pos_data", 64'(last_out), 64'(32767));
        check("sat_pos_flag", 64'(sat), 64'(1));

        // Negative saturation from a fresh reset
        do_reset();
        check("reset_clears_sat", 64'(sat), 64'(0));
        check("reset_clears_data", 64'(out_data), 64'(0));
        for (int a = 0; a < HALF; a++) write_coef(a, 256, 1'b1);
        repeat (12) feed(-16'sd32768);
        in_valid = 1'b0;
        drain();
        check("sat_neg_data", 64'(last_out), 64'(-32768));
        check("sat_neg_flag", 64'(sat), 64'(1));

        // Rounding with a half-gain centre tap
        do_reset();
        write_coef(CENTER, 128, 1'b1);
        repeat (6) feed(16'sd3);
        in_valid = 1'b0;
        drain();
        check("round_pos3", 64'(last_out), 64'(2));
        repeat (6) feed(-16'sd3);
        in_valid = 1'b0;
        drain();
        check("round_neg3", 64'(last_out), 64'(-1));
        repeat (6) feed(16'sd1);
        in_valid = 1'b0;
        drain();
        check("round_pos1", 64'(last_out), 64'(1));

        // Backpressure: result held, next sample waits, then both move together
        for (int a = 0; a < HALF; a++) write_coef(a, 256, 1'b1);
        out_ready = 1'b0;
        feed(16'sd400);
        in_valid = 1'b0;
        wait_out_valid();
        in_valid = 1'b1;
        in_data  = -16'sd400;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_data", 64'(out_data), (q_y.size() > 0) ? q_y[0] : 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Writes that must be dropped: during MAC, and out-of-range address
        feed(16'sd50);
        in_valid = 1'b0;
        write_coef(0, 4660, 1'b0);
        drain();
        write_coef(7, 1, 1'b0);
        feed(16'sd60);
        in_valid = 1'b0;
        drain();

        // Reset during MAC aborts without a partial output
        feed(16'sd1234);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        check("mid_reset_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        check("mid_reset_out_valid", 64'(out_valid), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        repeat (8) begin
            @(posedge clk);
            #1;
            check("post_reset_no_out", 64'(out_valid), 64'(0));
        end

        // Default passthrough restored
        feed(16'sd100);
        repeat (5) feed(16'sd0);
        in_valid = 1'b0;
        drain();
        check("passthrough_restored", 64'(last_out), 64'(100));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
